// File: rtl/trng_harvest_ctrl.sv
// Ring-oscillator entropy harvester: warmup, sampling, debias, byte packing, repetition health test.
// Optional TRNG_VN_DEBIAS_EN enables the von Neumann pair debiaser; otherwise samples shift in directly.
module trng_harvest_ctrl #(
  parameter int NUM_RO     = 4,
  parameter int SAMPLE_DIV = 16,
  parameter int WARMUP_CYC = 64,
  parameter int REP_LIMIT  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear_fail,
  output logic [NUM_RO-1:0] ro_en,
  input  logic [NUM_RO-1:0] ro_raw,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              health_fail,
  output logic              busy
);

  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WARM_W = $clog2(WARMUP_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_COLLECT, S_HOLD, S_FAIL} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_RO-1:0]   r_sync1;
  logic [NUM_RO-1:0]   r_sync2;
  logic [WARM_W-1:0]   r_warm_cnt;
  logic [DIV_W-1:0]    r_div;
  logic [7:0]          r_rep_cnt;
  logic                r_prev;
  logic [7:0]          r_shift;
  logic [3:0]          r_bit_cnt;
  logic                w_sample;
  logic                w_tick;
  logic [7:0]          w_rep_nxt;
  logic                w_trip;
  logic                w_bit_acc;
  logic                w_bit_val;
  logic                w_byte_done;
  logic                w_drop_byte;

  assign w_sample  = ^r_sync2;
  assign w_tick    = (r_state == S_COLLECT) && (r_div == DIV_W'(SAMPLE_DIV - 1));
  // rep_cnt == 0 marks the first sample since entering COLLECT from warmup
  assign w_rep_nxt = ((r_rep_cnt == 8'd0) || (w_sample != r_prev)) ? 8'd1 : r_rep_cnt + 8'd1;
  assign w_trip    = w_tick && (w_rep_nxt == 8'(REP_LIMIT));

`ifdef TRNG_VN_DEBIAS_EN
  logic r_pair_vld;
  logic r_pair_bit;

  assign w_bit_acc = w_tick && !w_trip && r_pair_vld && (r_pair_bit != w_sample);
  assign w_bit_val = r_pair_bit;
`else
  assign w_bit_acc = w_tick && !w_trip;
  assign w_bit_val = w_sample;
`endif

  assign w_byte_done = w_bit_acc && (r_bit_cnt == 4'd7);
  assign w_drop_byte = (w_state_nxt == S_IDLE) || (w_state_nxt == S_WARMUP) ||
                       (w_state_nxt == S_FAIL) ||
                       ((r_state == S_HOLD) && (w_state_nxt == S_COLLECT));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (enable) w_state_nxt = S_WARMUP;
      S_WARMUP: begin
        if (!enable)                 w_state_nxt = S_IDLE;
        else if (r_warm_cnt == '0)   w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        if (w_trip)                  w_state_nxt = S_FAIL;
        else if (!enable)            w_state_nxt = S_IDLE;
        else if (w_byte_done)        w_state_nxt = S_HOLD;
      end
      S_HOLD:    if (byte_ready) w_state_nxt = enable ? S_COLLECT : S_IDLE;
      S_FAIL:    if (clear_fail) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ro_en       = '0;
    byte_valid  = 1'b0;
    health_fail = 1'b0;
    busy        = (r_state != S_IDLE);
    byte_out    = r_shift;
    if ((r_state == S_WARMUP) || (r_state == S_COLLECT) || (r_state == S_HOLD)) ro_en = '1;
    if (r_state == S_HOLD) byte_valid = 1'b1;
    if (r_state == S_FAIL) health_fail = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_warm_cnt <= '0;
      r_div      <= '0;
      r_rep_cnt  <= 8'd0;
      r_prev     <= 1'b0;
      r_shift    <= 8'd0;
      r_bit_cnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sync1 <= ro_raw;
      r_sync2 <= r_sync1;

      if (r_state != S_WARMUP)    r_warm_cnt <= WARM_W'(WARMUP_CYC - 1);
      else if (r_warm_cnt != '0)  r_warm_cnt <= r_warm_cnt - WARM_W'(1);

      if (r_state != S_COLLECT)   r_div <= '0;
      else if (w_tick)            r_div <= '0;
      else                        r_div <= r_div + DIV_W'(1);

      if (w_tick) begin
        r_rep_cnt <= w_rep_nxt;
        r_prev    <= w_sample;
      end else if ((r_state != S_COLLECT) && (r_state != S_HOLD)) begin
        r_rep_cnt <= 8'd0;
      end

      if (w_drop_byte) begin
        r_shift   <= 8'd0;
        r_bit_cnt <= 4'd0;
      end else if (w_bit_acc) begin
        r_shift   <= {r_shift[6:0], w_bit_val};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end
  end

`ifdef TRNG_VN_DEBIAS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pair_vld <= 1'b0;
      r_pair_bit <= 1'b0;
    end else if (w_drop_byte) begin
      r_pair_vld <= 1'b0;
      r_pair_bit <= 1'b0;
    end else if (w_tick && !w_trip) begin
      r_pair_vld <= !r_pair_vld;
      r_pair_bit <= w_sample;
    end
  end
`endif

endmodule
